pipe_seq_ctrl: RTL and testbench
================================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: clock-enabled cycles run after halt reaches EX/M output (drains M/WB); legal 1..15.
REQ-002 Parameter CNT_W, default 32: width of cycle counter.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  run request, single-cycle pulse.
REQ-006 i_step  in  1  single-step request, single-cycle pulse.
REQ-007 i_mode_step  in  1  1 = step mode, 0 = continuous mode.
REQ-008 i_halt_in  in  1  halt flag from EX/M register output.
REQ-009 i_id_ex_mem_read  in  1  instruction in ID/EX is a load.
REQ-010 i_id_ex_rt  in  5  load destination register in ID/EX.
REQ-011 i_if_id_rs, i_if_id_rt  in  5 each  source registers of instruction in IF/ID.
REQ-012 o_clk_en  out  1  enable for all segment registers (IF/ID, ID/EX, EX/M, M/WB) and register file.
REQ-013 o_pc_en  out  1  PC update enable.
REQ-014 o_if_id_en  out  1  IF/ID load enable.
REQ-015 o_id_ex_flush  out  1  inserts bubble into ID/EX (control bits zeroed).
REQ-016 o_running  out  1  high in RUN, STEP, DRAIN.
REQ-017 o_halted  out  1  high in HALTED.
REQ-018 o_cycle_count  out  CNT_W  count of enabled cycles.

Function
REQ-019 FSM states IDLE, RUN, STEP, DRAIN, HALTED; Moore outputs o_clk_en = o_running = (RUN|STEP|DRAIN).
REQ-020 IDLE: i_halt_in=1 -> DRAIN (highest priority); else i_mode_step=0 and i_start=1 -> RUN; else i_mode_step=1 and i_step=1 -> STEP; else stay; i_start ignored in step mode, i_step ignored in continuous mode.
REQ-021 Latency: request pulse in cycle n -> o_clk_en high in cycle n+1.
REQ-022 STEP lasts exactly one cycle, then -> DRAIN if i_halt_in=1, else IDLE.
REQ-023 RUN: i_halt_in=1 -> DRAIN; i_start/i_step ignored; otherwise stays in RUN.
REQ-024 DRAIN: 4-bit down-counter loaded with DRAIN_CYCLES on entry; o_clk_en high for exactly DRAIN_CYCLES cycles, then -> HALTED; all requests ignored.
REQ-025 HALTED: o_clk_en=0, o_halted=1; exits only via reset.
REQ-026 Load-use hazard H = i_id_ex_mem_read & (i_id_ex_rt!=0) & (i_id_ex_rt==i_if_id_rs | i_id_ex_rt==i_if_id_rt), combinational.
REQ-027 o_pc_en = o_if_id_en = o_clk_en & ~H & ~(state==DRAIN); o_id_ex_flush = o_clk_en & H.
REQ-028 DRAIN freezes PC and IF/ID so no instruction after halt enters ID/EX; downstream registers still advance.
REQ-029 Hazard stall does not change FSM state; a STEP cycle with H=1 consumes the step (bubble inserted).

Reset
REQ-030 i_reset=1 forces IDLE, drain counter 0, o_cycle_count 0 immediately, regardless of clock; all outputs 0 while asserted.
REQ-031 Reset mid-RUN or mid-DRAIN discards progress; first edge after release evaluates IDLE transitions.

Configuration
REQ-032 Macro PIPE_SEQ_CYCLE_COUNT_EN defined: o_cycle_count increments by 1 on every edge with o_clk_en=1, saturating at all-ones (no wrap).
REQ-033 Macro undefined: no counter logic; o_cycle_count tied to 0.

Verification
REQ-034 Continuous: reset, mode_step=0, start pulse at cycle 3 -> o_clk_en=1 from cycle 4; halt_in raised cycle 10 -> clk_en high cycles 11-12 (DRAIN_CYCLES=2), o_halted=1 from cycle 13; count=9 (macro on).
REQ-035 Step: mode_step=1, three step pulses 5 cycles apart -> exactly three single-cycle clk_en pulses, each one cycle after its step; start pulses ignored.
REQ-036 Load-use: RUN, mem_read=1, id_ex_rt=5, if_id_rs=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; id_ex_rt=0 with rs=0 -> no stall.
REQ-037 Saturation: CNT_W=4, macro on, run 20 cycles -> o_cycle_count holds 15.
REQ-038 Async reset: assert i_reset mid-DRAIN between edges -> o_clk_en, o_running drop same time step; after release, halt_in=0, no start -> stays IDLE.
REQ-039 Macro off: same stimulus as REQ-034 -> o_cycle_count=0 throughout, FSM behaviour identical.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_seq_ctrl
//   Run / single-step / halt-drain sequencer for a 5-stage pipeline, plus
//   load-use hazard stall generation.
//
//   The controller gates every segment register and the register file
//   through o_clk_en. It also freezes the PC and the IF/ID register on a
//   load-use hazard and during the post-halt drain. An optional counter
//   tracks how many enabled cycles have run.
//
//   Optional feature macro: PIPE_SEQ_CYCLE_COUNT_EN
//     defined   -> o_cycle_count counts enabled cycles, saturating at all-ones
//     undefined -> no counter logic, o_cycle_count tied to 0
//
// Parameters
//   DRAIN_CYCLES  enabled cycles run after halt reaches EX/M (1..15)
//   CNT_W         width of o_cycle_count
//
// Ports
//   i_clk              clock, rising edge
//   i_reset            asynchronous, active-high reset
//   i_start            run request pulse (continuous mode only)
//   i_step             single-step request pulse (step mode only)
//   i_mode_step        1 = step mode, 0 = continuous mode
//   i_halt_in          halt flag from EX/M register output
//   i_id_ex_mem_read   ID/EX instruction is a load
//   i_id_ex_rt         load destination register in ID/EX
//   i_if_id_rs/_rt     source registers of the IF/ID instruction
//   o_clk_en           enable for segment registers and register file
//   o_pc_en            PC update enable
//   o_if_id_en         IF/ID load enable
//   o_id_ex_flush      zero the ID/EX control bits (bubble)
//   o_running          high in RUN, STEP, DRAIN
//   o_halted           high in HALTED
//   o_cycle_count      enabled-cycle count
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | pipeline frozen, waiting for start / step / halt
// RUN    | continuous execution until halt reaches EX/M
// STEP   | exactly one enabled cycle
// DRAIN  | PC and IF/ID frozen, M and WB run DRAIN_CYCLES more cycles
// HALTED | pipeline frozen; only reset leaves this state
// ---------------------------------------------------------------------------
module pipe_seq_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_mode_step,
    input  logic             i_halt_in,
    input  logic             i_id_ex_mem_read,
    input  logic [4:0]       i_id_ex_rt,
    input  logic [4:0]       i_if_id_rs,
    input  logic [4:0]       i_if_id_rt,
    output logic             o_clk_en,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_flush,
    output logic             o_running,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [3:0] drain_cnt;
    logic [3:0] drain_cnt_next;
    logic       clk_en;
    logic       halted;
    logic       hazard;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        clk_en         = 1'b0;
        halted         = 1'b0;
        case (state)
            IDLE: begin
                if (i_halt_in) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else if (!i_mode_step && i_start) begin
                    state_next = RUN;
                end else if (i_mode_step && i_step) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                clk_en = 1'b1;
                if (i_halt_in) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            STEP: begin
                clk_en = 1'b1;
                if (i_halt_in) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                clk_en = 1'b1;
                // Terminal count at 1: the cycle that sees 1 is the last
                // enabled drain cycle.
                if (drain_cnt <= 4'd1) begin
                    state_next     = HALTED;
                    drain_cnt_next = 4'd0;
                end else begin
                    drain_cnt_next = drain_cnt - 4'd1;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next     = IDLE;
                drain_cnt_next = 4'd0;
            end
        endcase
    end

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign hazard = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

    assign o_clk_en      = clk_en;
    assign o_running     = clk_en;
    assign o_halted      = halted;
    // During DRAIN nothing younger than the halt may enter ID/EX.
    assign o_pc_en       = clk_en && !hazard && (state != DRAIN);
    assign o_if_id_en    = clk_en && !hazard && (state != DRAIN);
    assign o_id_ex_flush = clk_en && hazard;

`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycle_count <= '0;
        end else if (clk_en && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign o_cycle_count = cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_seq_ctrl
//   Two instances share stimulus: u_a uses defaults (DRAIN_CYCLES=2,
//   CNT_W=32), u_b uses DRAIN_CYCLES=3, CNT_W=4. A behavioural model tracks
//   the sequencer mode, remaining drain cycles and enabled-cycle count for
//   each instance.
// ---------------------------------------------------------------------------
module tb_pipe_seq_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALT = 4;
`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, step, mode, halt, mr;
    logic [4:0] ex_rt, rs, rt;
    logic       clk_en [2];
    logic       pc_en  [2];
    logic       ifid_en[2];
    logic       flush  [2];
    logic       running[2];
    logic       halted [2];
    logic [31:0] cnt0;
    logic [3:0]  cnt1;

    int    errors = 0;
    int    checks = 0;
    int    m_mode [2];
    int    m_left [2];
    longint m_cnt [2];
    int    dc   [2] = '{2, 3};
    longint cmax[2] = '{64'hFFFF_FFFF, 64'd15};

    always #5 clk = ~clk;

    pipe_seq_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) u_a (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_step(step),
        .i_mode_step(mode), .i_halt_in(halt), .i_id_ex_mem_read(mr),
        .i_id_ex_rt(ex_rt), .i_if_id_rs(rs), .i_if_id_rt(rt),
        .o_clk_en(clk_en[0]), .o_pc_en(pc_en[0]), .o_if_id_en(ifid_en[0]),
        .o_id_ex_flush(flush[0]), .o_running(running[0]), .o_halted(halted[0]),
        .o_cycle_count(cnt0)
    );

    pipe_seq_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) u_b (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_step(step),
        .i_mode_step(mode), .i_halt_in(halt), .i_id_ex_mem_read(mr),
        .i_id_ex_rt(ex_rt), .i_if_id_rs(rs), .i_if_id_rt(rt),
        .o_clk_en(clk_en[1]), .o_pc_en(pc_en[1]), .o_if_id_en(ifid_en[1]),
        .o_id_ex_flush(flush[1]), .o_running(running[1]), .o_halted(halted[1]),
        .o_cycle_count(cnt1)
    );

    // ---------------- reference model ----------------
    function automatic bit m_en(int k);
        return (m_mode[k] == M_RUN) || (m_mode[k] == M_STEP) || (m_mode[k] == M_DRAIN);
    endfunction

    function automatic bit m_hz();
        return mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE;
            m_left[k] = 0;
            m_cnt[k]  = 0;
        end
    endtask

    // Advance one rising edge; model sees the inputs that were present at it.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (m_en(k) && m_cnt[k] < cmax[k]) m_cnt[k]++;
                if (m_mode[k] == M_IDLE) begin
                    if (halt) begin m_mode[k] = M_DRAIN; m_left[k] = dc[k]; end
                    else if (!mode && start) m_mode[k] = M_RUN;
                    else if (mode && step) m_mode[k] = M_STEP;
                end else if (m_mode[k] == M_RUN) begin
                    if (halt) begin m_mode[k] = M_DRAIN; m_left[k] = dc[k]; end
                end else if (m_mode[k] == M_STEP) begin
                    if (halt) begin m_mode[k] = M_DRAIN; m_left[k] = dc[k]; end
                    else m_mode[k] = M_IDLE;
                end else if (m_mode[k] == M_DRAIN) begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_mode[k] = M_HALT;
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; step = 0; mode = 0; halt = 0; mr = 0;
        ex_rt = 0; rs = 0; rt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #3;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        start = 1; step = 1; halt = 1; mr = 1; ex_rt = 5'd4; rs = 5'd4; rt = 5'd4;
        #2;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({clk_en[k], running[k], halted[k], pc_en[k], ifid_en[k], flush[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got %b%b%b%b%b%b want 000000", k,
                         clk_en[k], running[k], halted[k], pc_en[k], ifid_en[k], flush[k]);
            end
        end
        checks++;
        if (cnt0 !== 32'd0 || cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got %0d/%0d want 0/0", cnt0, cnt1);
        end
        do_reset();
    endtask

    task automatic test_continuous();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            start = (c == 3);
            halt  = (c >= 10);
            #1;
            checks++;
            if (clk_en[0] !== (c >= 4 && c <= 12) || running[0] !== (c >= 4 && c <= 12)) begin
                errors++;
                $display("FAIL cont_clk_en cyc %0d got %b/%b want %b", c, clk_en[0], running[0],
                         (c >= 4 && c <= 12));
            end
            checks++;
            if (halted[0] !== (c >= 13) || pc_en[0] !== (c >= 4 && c <= 10)) begin
                errors++;
                $display("FAIL cont_halt_pc cyc %0d got halted=%b pc_en=%b want %b/%b", c,
                         halted[0], pc_en[0], (c >= 13), (c >= 4 && c <= 10));
            end
            checks++;
            if (clk_en[1] !== (c >= 4 && c <= 13) || halted[1] !== (c >= 14)) begin
                errors++;
                $display("FAIL cont_drain3 cyc %0d got clk_en=%b halted=%b", c, clk_en[1], halted[1]);
            end
            tick();
        end
        checks++;
        if (cnt0 !== (CNT_ON ? 32'd9 : 32'd0) || cnt1 !== (CNT_ON ? 4'd10 : 4'd0)) begin
            errors++;
            $display("FAIL cont_count got %0d/%0d want %0d/%0d", cnt0, cnt1,
                     CNT_ON ? 9 : 0, CNT_ON ? 10 : 0);
        end
    endtask

    task automatic test_step();
        do_reset();
        mode = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step  = (c == 2 || c == 7 || c == 12);
            start = (c == 4 || c == 9);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (clk_en[k] !== (c == 3 || c == 8 || c == 13)) begin
                    errors++;
                    $display("FAIL step_pulse[%0d] cyc %0d got %b want %b", k, c, clk_en[k],
                             (c == 3 || c == 8 || c == 13));
                end
            end
            tick();
        end
        checks++;
        if (cnt0 !== (CNT_ON ? 32'd3 : 32'd0) || cnt1 !== (CNT_ON ? 4'd3 : 4'd0)) begin
            errors++;
            $display("FAIL step_count got %0d/%0d want %0d", cnt0, cnt1, CNT_ON ? 3 : 0);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        mr = 1; ex_rt = 5'd5; rs = 5'd5;
        #1;
        checks++;
        if (flush[0] !== 1'b0 || pc_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL lu_idle got flush=%b pc_en=%b want 0/0", flush[0], pc_en[0]);
        end
        start = 1;
        tick();
        start = 0; rt = 5'd9;
        #1;
        checks++;
        if ({clk_en[0], pc_en[0], ifid_en[0], flush[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL lu_rs_stall got %b%b%b%b want 1001", clk_en[0], pc_en[0], ifid_en[0], flush[0]);
        end
        tick();
        ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
        #1;
        checks++;
        if ({clk_en[0], pc_en[0], ifid_en[0], flush[0]} !== 4'b1110) begin
            errors++;
            $display("FAIL lu_r0_nostall got %b%b%b%b want 1110", clk_en[0], pc_en[0], ifid_en[0], flush[0]);
        end
        ex_rt = 5'd7; rs = 5'd3; rt = 5'd7;
        #1;
        checks++;
        if ({pc_en[1], ifid_en[1], flush[1]} !== 3'b001) begin
            errors++;
            $display("FAIL lu_rt_stall got %b%b%b want 001", pc_en[1], ifid_en[1], flush[1]);
        end
        mr = 0;
        #1;
        checks++;
        if ({pc_en[0], flush[0]} !== 2'b10) begin
            errors++;
            $display("FAIL lu_noload got %b%b want 10", pc_en[0], flush[0]);
        end
        // A step with a hazard is consumed as a bubble.
        do_reset();
        mode = 1; step = 1;
        tick();
        step = 0; mr = 1; ex_rt = 5'd2; rs = 5'd2;
        #1;
        checks++;
        if ({clk_en[0], pc_en[0], flush[0]} !== 3'b101) begin
            errors++;
            $display("FAIL lu_step_bubble got %b%b%b want 101", clk_en[0], pc_en[0], flush[0]);
        end
        tick();
        checks++;
        if (clk_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL lu_step_consumed got %b want 0", clk_en[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        start = 1;
        tick();
        start = 0;
        repeat (20) tick();
        checks++;
        if (cnt1 !== (CNT_ON ? 4'd15 : 4'd0)) begin
            errors++;
            $display("FAIL sat_count4 got %0d want %0d", cnt1, CNT_ON ? 15 : 0);
        end
        checks++;
        if (cnt0 !== (CNT_ON ? 32'd20 : 32'd0)) begin
            errors++;
            $display("FAIL sat_count32 got %0d want %0d", cnt0, CNT_ON ? 20 : 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1;
        tick();
        start = 0; halt = 1;
        tick();
        checks++;
        if (clk_en[0] !== 1'b1 || pc_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL ar_in_drain got clk_en=%b pc_en=%b want 1/0", clk_en[0], pc_en[0]);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({clk_en[k], running[k], pc_en[k], halted[k]} !== 4'b0) begin
                errors++;
                $display("FAIL ar_drop[%0d] got %b%b%b%b want 0000", k, clk_en[k], running[k],
                         pc_en[k], halted[k]);
            end
        end
        tick();
        #2;
        halt = 0;
        rst  = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({clk_en[0], running[0], halted[0], clk_en[1]} !== 4'b0) begin
                errors++;
                $display("FAIL ar_idle cyc %0d got %b%b%b%b want 0000", c, clk_en[0], running[0],
                         halted[0], clk_en[1]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit     h, e;
        logic [5:0] want;
        longint got_c, want_c;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) model_reset();
            start = ($urandom_range(0, 7) == 0);
            step  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            halt  = ($urandom_range(0, 59) == 0);
            mr    = 1'($urandom_range(0, 1));
            ex_rt = 5'($urandom_range(0, 3));
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            #1;
            h = m_hz();
            for (int k = 0; k < 2; k++) begin
                e    = m_en(k);
                want = {e, e, (m_mode[k] == M_HALT), e && !h && (m_mode[k] != M_DRAIN),
                        e && !h && (m_mode[k] != M_DRAIN), e && h};
                checks++;
                if ({clk_en[k], running[k], halted[k], pc_en[k], ifid_en[k], flush[k]} !== want) begin
                    errors++;
                    $display("FAIL rand_outputs[%0d] cyc %0d got %b%b%b%b%b%b want %b", k, c,
                             clk_en[k], running[k], halted[k], pc_en[k], ifid_en[k], flush[k], want);
                end
                got_c  = (k == 0) ? longint'(cnt0) : longint'(cnt1);
                want_c = CNT_ON ? m_cnt[k] : 64'd0;
                checks++;
                if (got_c !== want_c) begin
                    errors++;
                    $display("FAIL rand_count[%0d] cyc %0d got %0d want %0d", k, c, got_c, want_c);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_continuous();
        test_step();
        test_load_use();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
